// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT constants, S-box/permutation helpers and encrypt FSM states
package present_pkg;
  localparam int BLOCK_SIZE = 64;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} enc_state_e;
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction
  function automatic logic [BLOCK_SIZE-1:0] s_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
    return y;
  endfunction
  function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[(16*i)%63] = x[i];
    return y;
  endfunction
endpackage

// File: rtl/present_encrypt_if.sv
// present_encrypt_if: host request/result bundle for the PRESENT encrypt core
interface present_encrypt_if import present_pkg::*; #(parameter int KEY_SIZE = 80);
  logic                  Start;
  logic [KEY_SIZE-1:0]   orig_key;
  logic [BLOCK_SIZE-1:0] plaintext;
  logic [BLOCK_SIZE-1:0] ciphertext;
  logic                  Done;
  logic                  Busy;
  modport master (output Start, orig_key, plaintext, input ciphertext, Done, Busy);
  modport slave (input Start, orig_key, plaintext, output ciphertext, Done, Busy);
endinterface

// File: rtl/present_key_update.sv
// present_key_update: combinational PRESENT key schedule step for 80- or 128-bit keys
module present_key_update import present_pkg::*; #(
  parameter int KEY_SIZE = 80
) (
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic [4:0]          round_ctr_i,
  output logic [KEY_SIZE-1:0] key_o
);
  logic [KEY_SIZE-1:0] rot;
  assign rot = {key_i[KEY_SIZE-62:0], key_i[KEY_SIZE-1:KEY_SIZE-61]};
  if (KEY_SIZE == 80) begin : g_k80
    assign key_o = {sbox4(rot[79:76]), rot[75:20], rot[19:15] ^ round_ctr_i, rot[14:0]};
  end else if (KEY_SIZE == 128) begin : g_k128
    assign key_o = {sbox4(rot[127:124]), sbox4(rot[123:120]), rot[119:67],
                    rot[66:62] ^ round_ctr_i, rot[61:0]};
  end else begin : g_bad
    $error("present_key_update: KEY_SIZE must be 80 or 128");
  end
endmodule

// File: rtl/present_encrypt.sv
// present_encrypt: iterative PRESENT encryption, one round per clock plus final whitening
module present_encrypt import present_pkg::*; #(
  parameter int KEY_SIZE = 80,
  parameter int ROUNDS   = 31
) (
  input logic             Clock,
  input logic             Reset,
  present_encrypt_if.slave bus
);
  localparam logic [4:0] LAST = 5'(ROUNDS);
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_encrypt: ROUNDS must fit the 5-bit round counter");
  end
  enc_state_e            state_q, state_d;
  logic [BLOCK_SIZE-1:0] state_reg_q, state_reg_d, ct_q, ct_d, round_key;
  logic [KEY_SIZE-1:0]   key_reg_q, key_reg_d, key_next;
  logic [4:0]            round_ctr_q, round_ctr_d;
  logic                  done_q, done_d, accept;
  assign round_key = key_reg_q[KEY_SIZE-1 -: BLOCK_SIZE];
  assign accept    = state_q == ST_IDLE && bus.Start;
  present_key_update #(.KEY_SIZE(KEY_SIZE)) u_key_update (
    .key_i      (key_reg_q),
    .round_ctr_i(round_ctr_q),
    .key_o      (key_next)
  );
  // FSM state register
  always_ff @(posedge Clock) state_q <= Reset ? ST_IDLE : state_d;
  // FSM next state: rounds run until the counter reaches the last round, then one whitening cycle
  always_comb
    state_d = state_q == ST_IDLE  ? (bus.Start ? ST_ROUND : ST_IDLE) :
              state_q == ST_ROUND ? (round_ctr_q == LAST ? ST_FINAL : ST_ROUND) : ST_IDLE;
  // datapath next values: load on accept, iterate in ROUND, publish in FINAL
  always_comb begin
    state_reg_d = accept ? bus.plaintext :
                  state_q == ST_ROUND ? p_layer(s_layer(state_reg_q ^ round_key)) : state_reg_q;
    key_reg_d   = accept ? bus.orig_key : state_q == ST_ROUND ? key_next : key_reg_q;
    round_ctr_d = accept ? 5'd1 : state_q == ST_ROUND ? round_ctr_q + 5'd1 : round_ctr_q;
    ct_d        = state_q == ST_FINAL ? state_reg_q ^ round_key : ct_q;
    done_d      = state_q == ST_FINAL;
  end
  // datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg_q <= '0;
      key_reg_q   <= '0;
      round_ctr_q <= '0;
      ct_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      round_ctr_q <= round_ctr_d;
      ct_q        <= ct_d;
      done_q      <= done_d;
    end
  end
  // FSM outputs
  always_comb begin
    bus.ciphertext = ct_q;
    bus.Done       = done_q;
    bus.Busy       = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_present_encrypt.sv
// tb_present_encrypt: directed and random checks of present_encrypt against known vectors and a decrypt model
module tb_present_encrypt;
  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] exp;
    bit          known;
  } item_t;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;
  item_t sb[$];
  logic [3:0] sb_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] si_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                            4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  present_encrypt_if #(.KEY_SIZE(80))  b80 ();
  present_encrypt_if #(.KEY_SIZE(128)) b128 ();
  present_encrypt #(.KEY_SIZE(80), .ROUNDS(31)) dut80 (.Clock(Clock), .Reset(Reset), .bus(b80.slave));
  present_encrypt #(.KEY_SIZE(128), .ROUNDS(31)) dut128 (.Clock(Clock), .Reset(Reset), .bus(b128.slave));
  always #5 Clock = ~Clock;
  function automatic logic [63:0] dec80(input logic [63:0] c, input logic [79:0] k);
    logic [63:0] rk [33];
    logic [63:0] s, t;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sb_t[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = c ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      t[63] = s[63];
      for (int i = 0; i < 63; i++) t[i] = s[(16*i)%63];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = si_t[t[4*j +: 4]];
      s = s ^ rk[r];
    end
    return s;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go80(input logic [79:0] k, input logic [63:0] p, input logic [63:0] e, input bit known);
    sb.push_back('{k, p, e, known});
    b80.Start = 1'b1;
    b80.orig_key = k;
    b80.plaintext = p;
    @(negedge Clock);
    b80.Start = 1'b0;
  endtask
  task automatic wait80(input string tag, input int mid);
    int n;
    bit bok;
    item_t it;
    n = 0;
    bok = 1'b1;
    while (b80.Done !== 1'b1 && n < 200) begin
      if (b80.Busy !== 1'b1) bok = 1'b0;
      if (n == mid) begin
        b80.Start = 1'b1;
        b80.orig_key = 80'({$urandom, $urandom, $urandom});
        b80.plaintext = {$urandom, $urandom};
      end
      if (n == mid + 1) b80.Start = 1'b0;
      @(negedge Clock);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_busy_during"}, 64'(bok), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(b80.Busy), 64'd0);
    if (sb.size() == 0) chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    else begin
      it = sb.pop_front();
      if (it.known) chk({tag, "_ct"}, b80.ciphertext, it.exp);
      else chk({tag, "_roundtrip"}, dec80(b80.ciphertext, it.key), it.pt);
    end
    @(negedge Clock);
    chk({tag, "_done_pulse"}, 64'(b80.Done), 64'd0);
  endtask
  initial begin
    logic [79:0] vk [4];
    logic [63:0] vp [4];
    logic [63:0] ve [4];
    item_t it;
    int n, first, second;
    bit seen;
    vk = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
    vp = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};
    ve = '{64'h5579C1387B228445, 64'hE72C46C0F5945049, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    b80.Start = 1'b0;
    b80.orig_key = '0;
    b80.plaintext = '0;
    b128.Start = 1'b0;
    b128.orig_key = '0;
    b128.plaintext = '0;
    repeat (2) @(negedge Clock);
    chk("reset_busy", 64'(b80.Busy), 64'd0);
    chk("reset_done", 64'(b80.Done), 64'd0);
    chk("reset_ct", b80.ciphertext, 64'd0);
    Reset = 1'b0;
    @(negedge Clock);
    for (int v = 0; v < 4; v++) begin
      go80(vk[v], vp[v], ve[v], 1'b1);
      wait80($sformatf("vec%0d", v), -1);
    end
    go80(vk[1], vp[1], ve[1], 1'b1);
    wait80("midrun_change", 10);
    sb.push_back('{vk[0], vp[0], ve[0], 1'b1});
    sb.push_back('{vk[3], vp[3], ve[3], 1'b1});
    b80.Start = 1'b1;
    b80.orig_key = vk[0];
    b80.plaintext = vp[0];
    @(negedge Clock);
    n = 0;
    first = -1;
    second = -1;
    while (n < 200 && second < 0) begin
      if (n == 5) begin
        b80.orig_key = vk[3];
        b80.plaintext = vp[3];
      end
      if (n == 33) b80.Start = 1'b0;
      if (b80.Done === 1'b1) begin
        if (first < 0) first = n;
        else second = n;
        it = sb.pop_front();
        chk("b2b_ct", b80.ciphertext, it.exp);
      end
      @(negedge Clock);
      n++;
    end
    chk("b2b_first_done", 64'(first), 64'd32);
    chk("b2b_second_done", 64'(second), 64'd65);
    b80.Start = 1'b1;
    b80.orig_key = vk[1];
    b80.plaintext = vp[1];
    @(negedge Clock);
    b80.Start = 1'b0;
    repeat (15) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_busy", 64'(b80.Busy), 64'd0);
    chk("abort_ct", b80.ciphertext, 64'd0);
    chk("abort_done", 64'(b80.Done), 64'd0);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clock);
      seen = seen | b80.Done;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    go80(vk[2], vp[2], ve[2], 1'b1);
    wait80("after_abort", -1);
    for (int r = 0; r < 100; r++) begin
      go80(80'({$urandom, $urandom, $urandom}), {$urandom, $urandom}, 64'd0, 1'b0);
      wait80($sformatf("rand%0d", r), -1);
    end
    b128.Start = 1'b1;
    @(negedge Clock);
    b128.Start = 1'b0;
    n = 0;
    while (b128.Done !== 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("k128_latency", 64'(n), 64'd32);
    chk("k128_ct", b128.ciphertext, 64'h96DB702A2E6900AF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/present_encrypt.md
Name: present_encrypt

Overview:
Iterative PRESENT block-cipher encryption core, one round per clock cycle. It is the forward-direction counterpart of the existing Decrypt block, with a matching port style (orig_key, plaintext/ciphertext, Clock, Reset, Done). Ciphertext produced here must decrypt back to the original plaintext through Decrypt under the same key. It sits between the host-side key/data registers and the cipher output path.

Parameters:
- KEY_SIZE, 80, key width; 80 or 128 only, other values are an elaboration error.
- ROUNDS, 31, number of full rounds; a final key whitening follows them.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- orig_key  in  KEY_SIZE  cipher key; sampled on accepted Start.
- plaintext  in  64  input block; sampled on accepted Start.
- ciphertext  out  64  result; valid from Done onward, held until the next completion or Reset.
- Done  out  1  one-cycle pulse when ciphertext updates.
- Busy  out  1  high while an encryption is in progress.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - state goes to IDLE.
  - ciphertext=0, Done=0, Busy=0.
  - state_reg, key_reg and round_ctr are cleared.
  - Reset overrides Start.
  - Reset mid-encryption aborts the operation; no Done is produced.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - Start=1 latches plaintext into state_reg and orig_key into key_reg, sets round_ctr=1, then moves to ROUND. Busy=1 from the next cycle.
  - Start=0 keeps the block in IDLE.
- ROUND, each edge:
  - state_reg <= pLayer(sLayer(state_reg ^ key_reg[KEY_SIZE-1 -: 64])).
  - key_reg <= key_update(key_reg, round_ctr).
  - round_ctr <= round_ctr+1.
  - When round_ctr==ROUNDS the block moves to FINAL.
- FINAL, one edge:
  - ciphertext <= state_reg ^ key_reg[KEY_SIZE-1 -: 64].
  - Done <= 1, Busy <= 0, then back to IDLE.
- Done is high for exactly one cycle.
- Start is ignored while Busy=1; it is not queued.
- Start held high continuously gives back-to-back encryptions with one IDLE cycle between them.
- Latency: Start sampled at edge 0 → Done and ciphertext visible after edge ROUNDS+1 (32 cycles by default).
- Throughput: one block per ROUNDS+2 cycles.
- sLayer: 16 parallel 4-bit S-box lookups, S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16*i) mod 63 for i<63; bit 63 is fixed.
- key_update, KEY_SIZE=80:
  - rotate left 61.
  - apply S to [79:76].
  - [19:15] ^= round_ctr[4:0].
- key_update, KEY_SIZE=128:
  - rotate left 61.
  - apply S to [127:124] and to [123:120].
  - [66:62] ^= round_ctr[4:0].
- round_ctr is 5 bits and never wraps within a legal run; after FINAL it is don't-care.
- Changes on orig_key or plaintext while Busy=1 have no effect.

Decomposition:
- Shared package present_pkg holds:
  - BLOCK_SIZE=64 and the SBOX constant array.
  - functions sbox4, s_layer, p_layer.
  - the encrypt state enum.
- Decrypt reuses the same package for the inverse tables (adds the inverse S-box and inverse pLayer).
- One sub-module: present_key_update. It is combinational, parameterised by KEY_SIZE, and takes key_reg and round_ctr to produce the next key.

Test Plan:
- KEY_SIZE=80, key=0, pt=0000000000000000, Start one cycle → Done exactly 32 cycles later, ciphertext=5579C1387B228445, Busy high for the 31 intermediate cycles.
- key=FFFFFFFFFFFFFFFFFFFF, pt=0 → ciphertext=E72C46C0F5945049.
- key=0, pt=FFFFFFFFFFFFFFFF → A112FFC72F68417B; key=all F, pt=all F → 3333DCD3213210D2.
- Start pulsed and inputs changed mid-run (cycle 10) → result unchanged; Start stays high → second Done at cycle 65 with correct second result.
- Reset asserted at cycle 15 of a run → next edge Busy=0, ciphertext=0, no Done. A fresh Start then completes correctly.
- Round-trip: 100 random key/pt pairs through present_encrypt then Decrypt → recovered plaintext equals the original. For KEY_SIZE=128: key=0, pt=0 → 96DB702A2E6900AF.
